// File: rtl/noc_pkg.sv
// Shared NoC types: flit layout and source identifiers for the merge tree.
package noc_pkg;
  localparam int unsigned FLIT_W  = 9;
  localparam int unsigned ADDR_HI = 8;
  localparam int unsigned ADDR_LO = 5;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_t;
endpackage

// File: rtl/merge2_arbiter_if.sv
// Two source links plus one output link of the 2-to-1 merge node.
interface merge2_arbiter_if;
  import noc_pkg::*;

  logic  in0_valid;
  flit_t in0_data;
  logic  in0_ready;
  logic  in1_valid;
  flit_t in1_data;
  logic  in1_ready;
  logic  out_valid;
  flit_t out_data;
  src_t  out_src;
  logic  out_ready;

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; priority flips away from each granted source.
module rr_arb2
  import noc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output src_t       gnt_id
);

  src_t prio;

  always_comb begin
    gnt_id = prio;
    gnt    = 2'b00;
    case (req)
      2'b01:   gnt_id = SRC0;
      2'b10:   gnt_id = SRC1;
      default: gnt_id = prio;
    endcase
    if (en && (|req)) begin
      gnt = (gnt_id == SRC1) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= SRC0;
    end else if (en && (|req)) begin
      prio <= (gnt_id == SRC0) ? SRC1 : SRC0;
    end
  end

endmodule

// File: rtl/merge2_arbiter.sv
// 2-to-1 NoC merge: round-robin grant into a single-entry output register,
// with saturating per-source grant counters for debug.
module merge2_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  merge2_arbiter_if.slave  bus,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic       load;
  logic       arb_en;
  logic [1:0] gnt;
  src_t       gnt_id;

  // Register may take a new flit when empty or draining this cycle.
  assign load   = !bus.out_valid || bus.out_ready;
  assign arb_en = load && !reset;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({bus.in1_valid, bus.in0_valid}),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign bus.in0_ready = gnt[0];
  assign bus.in1_ready = gnt[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= SRC0;
    end else if (|gnt) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= gnt[1] ? bus.in1_data : bus.in0_data;
      bus.out_src   <= gnt_id;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt[0] && (gnt_cnt0 != CNT_MAX)) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      if (gnt[1] && (gnt_cnt1 != CNT_MAX)) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_merge2_arbiter.sv
// Scoreboard bench for merge2_arbiter: a default-width instance and a
// CNT_W=2 instance for counter saturation.
module tb_merge2_arbiter;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] cnt0_m, cnt1_m;
  logic [1:0] cnt0_s, cnt1_s;

  merge2_arbiter_if m ();
  merge2_arbiter_if s ();

  merge2_arbiter #(.CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .bus(m), .gnt_cnt0(cnt0_m), .gnt_cnt1(cnt1_m)
  );

  merge2_arbiter #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .bus(s), .gnt_cnt0(cnt0_s), .gnt_cnt1(cnt1_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] q_m[$];
  logic [9:0] q_s[$];
  int         pop_src[$];
  int         pop_cyc[$];
  int         sat_pops = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard for the main instance: drain first, then capture new accepts.
  always @(negedge clk) begin
    logic [9:0] e;
    if (reset) begin
      q_m.delete();
    end else begin
      if (m.in0_ready && m.in1_ready) check("one_ready", 1, 0);
      if (m.out_valid && m.out_ready) begin
        if (q_m.size() == 0) check("sb_underflow", 1, 0);
        else begin
          e = q_m.pop_front();
          check("out_data", 32'(m.out_data), 32'(e[8:0]));
          check("out_src", 32'(m.out_src), 32'(e[9]));
          pop_src.push_back(int'(m.out_src));
          pop_cyc.push_back(cyc);
        end
      end
      if (m.in0_valid && m.in0_ready) q_m.push_back({1'b0, m.in0_data});
      if (m.in1_valid && m.in1_ready) q_m.push_back({1'b1, m.in1_data});
    end
  end

  always @(negedge clk) begin
    logic [9:0] e;
    if (reset) begin
      q_s.delete();
    end else begin
      if (s.out_valid && s.out_ready) begin
        if (q_s.size() == 0) check("sat_underflow", 1, 0);
        else begin
          e = q_s.pop_front();
          check("sat_out_data", 32'(s.out_data), 32'(e[8:0]));
          sat_pops++;
        end
      end
      if (s.in0_valid && s.in0_ready) q_s.push_back({1'b0, s.in0_data});
      if (s.in1_valid && s.in1_ready) q_s.push_back({1'b1, s.in1_data});
    end
  end

  function automatic logic rdy(input int d, input int src);
    if (d == 0) return (src == 0) ? m.in0_ready : m.in1_ready;
    return (src == 0) ? s.in0_ready : s.in1_ready;
  endfunction

  task automatic drive(input int d, input int src, input logic v, input logic [8:0] x);
    if (d == 0) begin
      if (src == 0) begin m.in0_valid = v; m.in0_data = x; end
      else          begin m.in1_valid = v; m.in1_data = x; end
    end else begin
      if (src == 0) begin s.in0_valid = v; s.in0_data = x; end
      else          begin s.in1_valid = v; s.in1_data = x; end
    end
  endtask

  // Hold valid/data until the accepting edge, then drop valid.
  task automatic send(input int d, input int src, input logic [8:0] x);
    int n = 0;
    drive(d, src, 1'b1, x);
    do begin
      @(negedge clk);
      n++;
    end while (!rdy(d, src) && n < 200);
    if (n >= 200) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    drive(d, src, 1'b0, x);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    pop_src.delete();
    pop_cyc.delete();
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    m.in0_valid = 1'b0; m.in0_data = '0; m.in1_valid = 1'b0; m.in1_data = '0;
    m.out_ready = 1'b0;
    s.in0_valid = 1'b0; s.in0_data = '0; s.in1_valid = 1'b0; s.in1_data = '0;
    s.out_ready = 1'b1;

    // Reset values with a flit offered.
    m.in0_valid = 1'b1; m.in0_data = 9'h0AA;
    @(negedge clk);
    check("rst_out_valid", 32'(m.out_valid), 0);
    check("rst_out_data", 32'(m.out_data), 0);
    check("rst_out_src", 32'(m.out_src), 0);
    check("rst_in0_ready", 32'(m.in0_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Load one flit under stall, then reset mid-stream for 2 cycles.
    @(posedge clk); #1;
    check("pre_rst_valid", 32'(m.out_valid), 1);
    check("pre_rst_cnt0", 32'(cnt0_m), 1);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_in0_ready", 32'(m.in0_ready), 0);
      @(posedge clk); #1;
      check("midrst_out_valid", 32'(m.out_valid), 0);
      check("midrst_cnt0", 32'(cnt0_m), 0);
    end
    reset = 1'b0;
    m.in1_valid = 1'b1; m.in1_data = 9'h1B0;
    @(negedge clk);
    check("post_rst_gnt0", 32'(m.in0_ready), 1);
    check("post_rst_gnt1", 32'(m.in1_ready), 0);
    @(posedge clk); #1;
    m.in0_valid = 1'b0;
    m.out_ready = 1'b1;
    @(posedge clk); #1;
    m.in1_valid = 1'b0;
    settle();
    check("post_rst_order", 32'(pop_src.size() == 2 ? pop_src[0] * 2 + pop_src[1] : 99), 1);
    check("post_rst_cnt1", 32'(cnt1_m), 1);

    // Single source back-to-back.
    do_reset();
    send(0, 0, 9'h1A5);
    send(0, 0, 9'h0F3);
    send(0, 0, 9'h155);
    settle();
    check("single_cnt0", 32'(cnt0_m), 3);
    check("single_pops", 32'(pop_cyc.size()), 3);
    if (pop_cyc.size() == 3) check("single_no_bubble", 32'(pop_cyc[2] - pop_cyc[0]), 2);

    // Contention: alternate 0,1,0,1 with no gaps.
    do_reset();
    fork
      for (int i = 0; i < 6; i++) send(0, 0, 9'(9'h020 + i));
      for (int j = 0; j < 6; j++) send(0, 1, 9'(9'h140 + j));
    join
    settle();
    check("cont_cnt0", 32'(cnt0_m), 6);
    check("cont_cnt1", 32'(cnt1_m), 6);
    check("cont_pops", 32'(pop_src.size()), 12);
    if (pop_src.size() == 12) begin
      for (int k = 0; k < 12; k++) check("cont_alt", 32'(pop_src[k]), 32'(k % 2));
      check("cont_no_gap", 32'(pop_cyc[11] - pop_cyc[0]), 11);
    end

    // Backpressure: flit 0x123 held for 5 cycles, next flit loads on drain.
    do_reset();
    m.out_ready = 1'b0;
    send(0, 0, 9'h123);
    fork
      send(0, 1, 9'h056);
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(m.out_valid), 1);
      check("bp_out_data", 32'(m.out_data), 32'h123);
      check("bp_ready", 32'({m.in0_ready, m.in1_ready}), 0);
    end
    @(posedge clk); #1;
    m.out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_data", 32'(m.out_data), 32'h123);
    check("bp_same_cycle_load", 32'(m.in1_ready), 1);
    wait fork;
    settle();
    check("bp_pops", 32'(pop_src.size()), 2);

    // Priority after idle: single source-1 grant leaves prio on source 0.
    do_reset();
    send(0, 1, 9'h0C1);
    fork
      send(0, 0, 9'h011);
      send(0, 1, 9'h1C2);
    join
    settle();
    check("idle_pops", 32'(pop_src.size()), 3);
    if (pop_src.size() == 3) begin
      check("idle_first_both", 32'(pop_src[1]), 0);
      check("idle_second_both", 32'(pop_src[2]), 1);
    end

    // Saturation on the CNT_W=2 instance.
    for (int i = 0; i < 5; i++) send(1, 1, 9'(9'h0E0 + i));
    settle();
    check("sat_cnt1", 32'(cnt1_s), 3);
    check("sat_cnt0", 32'(cnt0_s), 0);
    check("sat_all_flits", 32'(sat_pops), 5);

    check("sb_empty_main", 32'(q_m.size()), 0);
    check("sb_empty_sat", 32'(q_s.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/merge2_arbiter.md
Name: merge2_arbiter

Overview:
- Synchronous 2-to-1 merge node for the NoC router tree.
- Shares one output link between two flit sources, e.g. the up-link fed by a local port and a sibling port.
- Round-robin arbitration into a single-entry output register with valid/ready handshakes.
- Reports the winning source with each flit and keeps saturating per-source grant counters for debug.

Parameters:
- FLIT_W, 9, flit width; bits [8:5] are the destination address, [4:0] the payload.
- CNT_W, 8, width of each saturating grant counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in0_valid  in  1  source 0 has a flit.
- in0_data  in  FLIT_W  source 0 flit.
- in0_ready  out  1  source 0 flit accepted this cycle.
- in1_valid  in  1  source 1 has a flit.
- in1_data  in  FLIT_W  source 1 flit.
- in1_ready  out  1  source 1 flit accepted this cycle.
- out_valid  out  1  output register holds a flit.
- out_data  out  FLIT_W  registered flit.
- out_src  out  1  source id of out_data (0 or 1).
- out_ready  in  1  downstream consumes the flit this cycle.
- gnt_cnt0  out  CNT_W  number of flits accepted from source 0, saturating.
- gnt_cnt1  out  CNT_W  number of flits accepted from source 1, saturating.

Behaviour:
- Clock and reset are fixed: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, out_src=0.
  - prio=0 (source 0 favoured).
  - gnt_cnt0=gnt_cnt1=0.
  - in0_ready and in1_ready read 0 while reset is high.
- Reset mid-operation: the flit in the output register is dropped; no input is accepted in the reset cycle.
- Handshakes:
  - A transfer occurs on a rising edge where valid && ready.
  - Sources hold valid and data stable until ready.
  - The downstream side may stall indefinitely.
- Load enable: load = !out_valid || out_ready. A new flit may enter in the same cycle the old one drains.
- Arbitration, combinational, evaluated when load=1:
  - Only in0_valid: grant 0.
  - Only in1_valid: grant 1.
  - Both valid: grant prio.
  - Neither: no grant.
- in_ready: in{i}_ready = load && grant==i && !reset. At most one ready is high per cycle; in{i}_ready never asserts without in{i}_valid.
- Acceptance of source i, registered:
  - out_data <= in{i}_data, out_src <= i, out_valid <= 1.
  - prio <= ~i.
  - gnt_cnt{i} increments, holding at 2^CNT_W-1.
- No acceptance while out_ready=1: out_valid <= 0 and out_data/out_src hold.
- Stall (out_valid=1, out_ready=0): output fields hold; both in_ready are 0; prio holds.
- Latency and throughput:
  - 1 cycle from input acceptance to out_valid.
  - 1 flit per cycle when out_ready is held high.
  - Alternating grants under continuous two-sided load.
- Fairness: while both sources stay valid, neither is granted twice in a row.
- Contents: no flit is modified, duplicated or dropped, except by reset.
- Combinational paths:
  - in_ready depends on out_ready, the other source's valid and prio.
  - in{i}_ready does not depend on in{i}_data.

Decomposition:
- Package noc_pkg:
  - FLIT_W=9, ADDR_HI=8, ADDR_LO=5.
  - typedef logic [FLIT_W-1:0] flit_t.
  - typedef enum logic {SRC0, SRC1} src_t.
- Sub-module rr_arb2:
  - Inputs: req[1:0], en, clk, reset.
  - Outputs: one-hot gnt[1:0] and gnt_id.
  - Owns the prio register and updates it only when en && |req.
- Top module: output register, load logic and counters.

Test Plan:
- Reset mid-stream: 2 cycles of reset with a flit held -> out_valid=0, counters 0, no ready. First post-reset accept with both sources valid grants source 0.
- Single source: in0 sends 0x1A5, 0x0F3, 0x155 back-to-back with out_ready=1 -> outputs appear 1 cycle later in order, out_src=0, gnt_cnt0=3, no bubbles.
- Contention: both sources valid for 6 flits each with out_ready=1 -> out_src sequence 0,1,0,1,… with no gaps; gnt_cnt0=gnt_cnt1=6.
- Backpressure: out_ready=0 for 5 cycles with a flit held (0x123) -> out_data stable, both in_ready=0. On release, 0x123 drains and the next flit loads in the same cycle.
- Priority after idle: source 1 alone sends one flit, then both valid -> source 0 granted first (prio=0 after the source-1 grant).
- Saturation: CNT_W=2, 5 flits from source 1 -> gnt_cnt1 stops at 3; no flit lost (scoreboard of 5 flits matches).
